csr_unit: RTL

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap/return bookkeeping, interrupt pending/cause,
// 64-bit cycle/instret/time counters and a mtime/mtimecmp timer interrupt.
module csr_unit #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VALUE  = 32'h40001100,
  parameter logic [31:0] MTVEC_RESET = 32'h00000000,
  parameter int unsigned TIMER_DIV   = 1,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [11:0] waddr_i,
  input  logic [11:0] raddr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        illegal_o,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_val_i,
  input  logic        mret_i,
  input  logic        retire_i,
  input  logic        ext_irq_i,
  output logic        irq_pending_o,
  output logic [31:0] irq_cause_o,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o
);
  localparam logic [31:0] MTVEC_RST = (!VECTORED_EN || MTVEC_RESET[1]) ?
                                      {MTVEC_RESET[31:2], 2'b00} : MTVEC_RESET;
  localparam logic [15:0] PS_MAX = 16'(TIMER_DIV - 1);

  logic        r_mie_b, r_mpie, r_msip, r_meip;
  logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [31:0] r_cyc_lo, r_cyc_hi, r_ins_lo, r_ins_hi, r_tim_lo, r_tim_hi, r_cmp_lo, r_cmp_hi;
  logic [15:0] r_ps;

  logic        w_wr_ok, w_wr, w_rd_ill, w_tick, w_mtip;
  logic [31:0] w_mip, w_pend, w_mstatus, w_base;
  logic [63:0] w_cyc_n, w_ins_n, w_tim_n;

  // Written word wins; a write to the low word also suppresses that cycle's carry.
  function automatic logic [63:0] f_cnt(input logic [31:0] lo, input logic [31:0] hi,
                                        input logic inc, input logic wlo, input logic whi,
                                        input logic [31:0] d);
    logic [31:0] nlo, nhi;
    nlo = lo + {31'b0, inc};
    nhi = hi + {31'b0, inc & (&lo)};
    if (wlo) begin
      nlo = d;
      nhi = hi;
    end
    if (whi) nhi = d;
    return {nhi, nlo};
  endfunction

  always_comb begin
    w_wr_ok = 1'b0;
    case (waddr_i)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hB80, 12'hB82,
      12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3: w_wr_ok = 1'b1;
      default:                            w_wr_ok = 1'b0;
    endcase
  end

  assign w_wr      = we_i & w_wr_ok;
  assign w_tick    = (r_ps == PS_MAX);
  assign w_mtip    = {r_tim_hi, r_tim_lo} >= {r_cmp_hi, r_cmp_lo};
  assign w_mip     = {20'b0, r_meip, 3'b0, w_mtip, 3'b0, r_msip, 3'b0};
  assign w_pend    = w_mip & r_mie;
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie_b, 3'b0};
  assign w_base    = {r_mtvec[31:2], 2'b00};

  assign w_cyc_n = f_cnt(r_cyc_lo, r_cyc_hi, 1'b1, w_wr && waddr_i == 12'hB00,
                         w_wr && waddr_i == 12'hB80, data_i);
  assign w_ins_n = f_cnt(r_ins_lo, r_ins_hi, retire_i, w_wr && waddr_i == 12'hB02,
                         w_wr && waddr_i == 12'hB82, data_i);
  assign w_tim_n = f_cnt(r_tim_lo, r_tim_hi, w_tick, w_wr && waddr_i == 12'h7C0,
                         w_wr && waddr_i == 12'h7C1, data_i);

  assign irq_pending_o = r_mie_b & (|w_pend);
  assign mepc_o        = r_mepc;
  assign mstatus_o     = w_mstatus;
  assign illegal_o     = w_rd_ill | (we_i & ~w_wr_ok);

  always_comb begin
    if (w_pend[11])     irq_cause_o = 32'h8000000B;
    else if (w_pend[3]) irq_cause_o = 32'h80000003;
    else if (w_pend[7]) irq_cause_o = 32'h80000007;
    else                irq_cause_o = '0;
  end

  always_comb begin
    if (r_mtvec[1:0] == 2'b00 || !trap_cause_i[31]) trap_vector_o = w_base;
    else trap_vector_o = w_base + {trap_cause_i[29:0], 2'b00};
  end

  always_comb begin
    data_o   = '0;
    w_rd_ill = 1'b0;
    case (raddr_i)
      12'h300: data_o = w_mstatus;
      12'h301: data_o = MISA_VALUE;
      12'h304: data_o = r_mie;
      12'h305: data_o = r_mtvec;
      12'h340: data_o = r_mscratch;
      12'h341: data_o = r_mepc;
      12'h342: data_o = r_mcause;
      12'h343: data_o = r_mtval;
      12'h344: data_o = w_mip;
      12'hB00: data_o = r_cyc_lo;
      12'hB02: data_o = r_ins_lo;
      12'hB80: data_o = r_cyc_hi;
      12'hB82: data_o = r_ins_hi;
      12'hF11, 12'hF12, 12'hF13: data_o = '0;
      12'hF14: data_o = HART_ID;
      12'h7C0: data_o = r_tim_lo;
      12'h7C1: data_o = r_tim_hi;
      12'h7C2: data_o = r_cmp_lo;
      12'h7C3: data_o = r_cmp_hi;
      default: w_rd_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie_b    <= 1'b0;
      r_mpie     <= 1'b0;
      r_msip     <= 1'b0;
      r_meip     <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_cyc_lo   <= '0;
      r_cyc_hi   <= '0;
      r_ins_lo   <= '0;
      r_ins_hi   <= '0;
      r_tim_lo   <= '0;
      r_tim_hi   <= '0;
      r_cmp_lo   <= '1;
      r_cmp_hi   <= '1;
      r_ps       <= '0;
    end else begin
      r_meip <= ext_irq_i;
      r_ps   <= w_tick ? '0 : r_ps + 16'd1;
      {r_cyc_hi, r_cyc_lo} <= w_cyc_n;
      {r_ins_hi, r_ins_lo} <= w_ins_n;
      {r_tim_hi, r_tim_lo} <= w_tim_n;
      if (w_wr && waddr_i == 12'h7C2) r_cmp_lo   <= data_i;
      if (w_wr && waddr_i == 12'h7C3) r_cmp_hi   <= data_i;
      if (w_wr && waddr_i == 12'h304) r_mie      <= data_i & 32'h00000888;
      if (w_wr && waddr_i == 12'h340) r_mscratch <= data_i;
      if (w_wr && waddr_i == 12'h344) r_msip     <= data_i[3];
      if (w_wr && waddr_i == 12'h305)
        r_mtvec <= (!VECTORED_EN || data_i[1]) ? {data_i[31:2], 2'b00} : data_i;
      // Trap overrides mret and CSR writes on the trap-owned registers.
      if (trap_i) begin
        r_mepc   <= {trap_pc_i[31:2], 2'b00};
        r_mcause <= trap_cause_i;
        r_mtval  <= trap_val_i;
        r_mpie   <= r_mie_b;
        r_mie_b  <= 1'b0;
      end else begin
        if (mret_i) begin
          r_mie_b <= r_mpie;
          r_mpie  <= 1'b1;
        end else if (w_wr && waddr_i == 12'h300) begin
          r_mie_b <= data_i[3];
          r_mpie  <= data_i[7];
        end
        if (w_wr && waddr_i == 12'h341) r_mepc   <= {data_i[31:2], 2'b00};
        if (w_wr && waddr_i == 12'h342) r_mcause <= data_i;
        if (w_wr && waddr_i == 12'h343) r_mtval  <= data_i;
      end
    end
  end
endmodule
